control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Moore-style instruction sequencer for the 8-bit microcontroller; sits directly upstream of the data path and drives all of its load, increment and select strobes.
- Runs fetch/decode/execute from the data path's IR and condition-code outputs.
- Also drives the memory write strobe.

Parameters:
- None. Opcodes, ALU codes, bus codes and state encodings come from the shared package.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- IR  input  8  current instruction register from data path
- CCR_Result  input  4  flags NZVC (bit3=N, bit2=Z, bit1=V, bit0=C)
- IR_Load  output  1  load IR from BUS2
- MAR_Load  output  1  load MAR from BUS2
- PC_Load  output  1  load PC from BUS2 (has priority over PC_Inc in data path)
- PC_Inc  output  1  increment PC
- A_Load  output  1  load A from BUS2
- B_Load  output  1  load B from BUS2
- ALU_Sel  output  3  ALU op: ADD=000, SUB=001, AND=010, OR=011, INC=100, DEC=101
- CCR_Load  output  1  latch ALU flags
- Bus1_Sel  output  2  00=PC, 01=A, 10=B
- Bus2_Sel  output  2  00=ALU, 01=BUS1, 10=from_memory
- write  output  1  memory write of BUS1 to address MAR
- halted  output  1  illegal-opcode trap indicator (see Optional Feature)

Behaviour:
- Reset:
  - reset low forces state=FETCH_0 immediately.
  - All outputs are 0 while reset is low (outputs gated by reset).
  - First rising edge after release executes FETCH_0.
- Outputs are a pure function of state, IR and CCR_Result. Every strobe not listed for a state is 0. Default selects are 00.
- Memory read data is valid one cycle after MAR loads.
- Fetch sequence:
  - FETCH_0: Bus1=PC, Bus2=BUS1, MAR_Load.
  - FETCH_1: PC_Inc.
  - FETCH_2: Bus2=mem, IR_Load.
  - DECODE_3: no strobes; next state chosen from IR.
- Opcodes:
  - LDA_IMM 0x86, LDA_DIR 0x87, LDB_IMM 0x88, LDB_DIR 0x89
  - STA_DIR 0x96, STB_DIR 0x97
  - ADD_AB 0x42, SUB_AB 0x43, AND_AB 0x44, OR_AB 0x45
  - INCA 0x46, INCB 0x47, DECA 0x48, DECB 0x49
  - BRA 0x20, BMI 0x21, BEQ 0x23, BNE 0x24, BVS 0x25, BCS 0x27
- IMM loads:
  - S4: MAR<=PC.
  - S5: PC_Inc.
  - S6: Bus2=mem, A_Load or B_Load.
  - Next: FETCH_0. Total 7 cycles.
- DIR loads:
  - S4: MAR<=PC.
  - S5: PC_Inc.
  - S6: Bus2=mem, MAR_Load.
  - S7: wait.
  - S8: Bus2=mem, A_Load or B_Load.
  - Total 9 cycles.
- Stores:
  - S4, S5, S6 as DIR loads.
  - S7: Bus1=A (or B), write=1 for exactly one cycle.
  - Total 8 cycles.
- ALU ops (A op B -> A):
  - S4: Bus1=A, Bus2=ALU, ALU_Sel per op, A_Load, CCR_Load, in the same cycle.
  - Total 5 cycles.
- INC/DEC:
  - INCA/DECA use Bus1=A and load A.
  - INCB/DECB use Bus1=B and load B.
  - Both also assert CCR_Load.
- Branches:
  - Condition is evaluated in DECODE_3 from CCR_Result as sampled then.
  - Taken: S4 MAR<=PC, S5 wait, S6 Bus2=mem, PC_Load. 7 cycles.
  - Not taken: S4 PC_Inc only (skips the operand byte). 5 cycles.
  - BRA is always taken.
- Unknown opcode with feature off: NOP; DECODE_3 goes to FETCH_0.
- No two strobes that write the same register are ever asserted together.
- PC_Load and PC_Inc are mutually exclusive.
- PC wrap-around from 0xFF to 0x00 is the data path's concern; no special handling here.

Optional Feature:
- Macro: CU_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE_3 enters state HALT.
  - HALT holds all strobes 0 and halted=1.
  - HALT is exited only by reset.
- Undefined: unknown opcode is a NOP; halted is tied 0 and the HALT state is absent.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants
  - ALU_Sel codes
  - Bus1/Bus2 select codes
  - CCR bit indices
  - state enum typedef
- One combinational sub-module, branch_eval: takes IR and CCR_Result, returns a 1-bit taken signal.

Test Plan:
- Memory {00:86, 01:AA} after reset release → IR_Load asserted in cycle 3; S6 asserts A_Load with Bus2_Sel=10; A=0xAA after 7 cycles; next MAR_Load with PC=02.
- {00:96, 01:E0} with A=0x5C → write high for exactly one cycle, Bus1_Sel=01, MAR=E0, memory[E0]=5C; total 8 cycles.
- A=0x7F, B=0x01, opcode 0x42 → single cycle with ALU_Sel=000, Bus2_Sel=00, A_Load=1, CCR_Load=1; A=0x80, CCR=1010.
- BEQ {0x23, 0x40}:
  - Z=1 → PC_Load in S6, next fetch from 0x40.
  - Z=0 → single PC_Inc, next fetch from 0x02, no PC_Load.
- Reset pulled low during S7 of LDA_DIR → all outputs 0 in the same cycle; after release, fetch restarts at address 0x00, A unchanged by the aborted load.
- Opcode 0xFF:
  - With CU_ILLEGAL_TRAP_EN → halted=1 and no strobes for 20 cycles.
  - Without → next FETCH_0 at PC=01.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the 8-bit microcontroller.
//   - Opcodes, ALU_Sel codes, Bus1/Bus2 select codes, CCR bit indices.
//   - state_t: sequencer state encoding. HALT exists only when
//     CU_ILLEGAL_TRAP_EN is defined.
package cpu_pkg;

   localparam logic [7:0] OP_LDA_IMM = 8'h86;
   localparam logic [7:0] OP_LDA_DIR = 8'h87;
   localparam logic [7:0] OP_LDB_IMM = 8'h88;
   localparam logic [7:0] OP_LDB_DIR = 8'h89;
   localparam logic [7:0] OP_STA_DIR = 8'h96;
   localparam logic [7:0] OP_STB_DIR = 8'h97;
   localparam logic [7:0] OP_ADD_AB  = 8'h42;
   localparam logic [7:0] OP_SUB_AB  = 8'h43;
   localparam logic [7:0] OP_AND_AB  = 8'h44;
   localparam logic [7:0] OP_OR_AB   = 8'h45;
   localparam logic [7:0] OP_INCA    = 8'h46;
   localparam logic [7:0] OP_INCB    = 8'h47;
   localparam logic [7:0] OP_DECA    = 8'h48;
   localparam logic [7:0] OP_DECB    = 8'h49;
   localparam logic [7:0] OP_BRA     = 8'h20;
   localparam logic [7:0] OP_BMI     = 8'h21;
   localparam logic [7:0] OP_BEQ     = 8'h23;
   localparam logic [7:0] OP_BNE     = 8'h24;
   localparam logic [7:0] OP_BVS     = 8'h25;
   localparam logic [7:0] OP_BCS     = 8'h27;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_INC = 3'b100;
   localparam logic [2:0] ALU_DEC = 3'b101;

   localparam logic [1:0] BUS1_PC = 2'b00;
   localparam logic [1:0] BUS1_A  = 2'b01;
   localparam logic [1:0] BUS1_B  = 2'b10;

   localparam logic [1:0] BUS2_ALU  = 2'b00;
   localparam logic [1:0] BUS2_BUS1 = 2'b01;
   localparam logic [1:0] BUS2_MEM  = 2'b10;

   localparam int CCR_N = 3;
   localparam int CCR_Z = 2;
   localparam int CCR_V = 1;
   localparam int CCR_C = 0;

   typedef enum logic [4:0] {
      FETCH_0, FETCH_1, FETCH_2, DECODE_3,
      LDI_4, LDI_5, LDI_6,
      LDD_4, LDD_5, LDD_6, LDD_7, LDD_8,
      ST_4, ST_5, ST_6, ST_7,
      ALU_4,
      BRT_4, BRT_5, BRT_6,
      BRN_4
`ifdef CU_ILLEGAL_TRAP_EN
      , HALT
`endif
   } state_t;

   function automatic logic [2:0] alu_code(input logic [7:0] op);
      logic [2:0] code;
      case (op)
         OP_SUB_AB:         code = ALU_SUB;
         OP_AND_AB:         code = ALU_AND;
         OP_OR_AB:          code = ALU_OR;
         OP_INCA, OP_INCB:  code = ALU_INC;
         OP_DECA, OP_DECB:  code = ALU_DEC;
         default:           code = ALU_ADD;
      endcase
      return code;
   endfunction

   // Instructions whose register operand is B rather than A.
   function automatic logic uses_reg_b(input logic [7:0] op);
      return (op == OP_LDB_IMM) || (op == OP_LDB_DIR) || (op == OP_STB_DIR) ||
             (op == OP_INCB)    || (op == OP_DECB);
   endfunction

endpackage

// File: rtl/branch_eval.sv
// branch_eval: combinational branch-condition decode.
//   IR         - current instruction
//   CCR_Result - NZVC flags
//   taken      - 1 when IR is a branch whose condition holds (BRA always)
module branch_eval
   import cpu_pkg::*;
(
   input  logic [7:0] IR,
   input  logic [3:0] CCR_Result,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      case (IR)
         OP_BRA: taken = 1'b1;
         OP_BMI: taken = CCR_Result[CCR_N];
         OP_BEQ: taken = CCR_Result[CCR_Z];
         OP_BNE: taken = ~CCR_Result[CCR_Z];
         OP_BVS: taken = CCR_Result[CCR_V];
         OP_BCS: taken = CCR_Result[CCR_C];
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// control_unit: Moore-style fetch/decode/execute sequencer for the 8-bit
// microcontroller data path.
//   clk, reset (async, active low)
//   IR, CCR_Result              - from data path
//   IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
//   ALU_Sel, Bus1_Sel, Bus2_Sel - data path strobes/selects
//   write                       - memory write of BUS1 at MAR
//   halted                      - illegal-opcode trap indicator
// Build option: CU_ILLEGAL_TRAP_EN adds the HALT trap state; without it an
// unknown opcode is a NOP and halted is tied 0.
//
// state    | meaning
// FETCH_0  | MAR <= PC
// FETCH_1  | PC++ (memory read in flight)
// FETCH_2  | IR <= mem
// DECODE_3 | dispatch on IR, branch condition sampled here
// LDI_4..6 | immediate load: MAR<=PC, PC++, A/B <= mem
// LDD_4..8 | direct load: MAR<=PC, PC++, MAR<=mem, wait, A/B <= mem
// ST_4..7  | store: MAR<=PC, PC++, MAR<=mem, mem <= A/B
// ALU_4    | A/B <= ALU result, CCR latched
// BRT_4..6 | taken branch: MAR<=PC, wait, PC <= mem
// BRN_4    | untaken branch: skip operand byte
// HALT     | illegal opcode trap (CU_ILLEGAL_TRAP_EN only)
module control_unit
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] IR,
   input  logic [3:0] CCR_Result,
   output logic       IR_Load,
   output logic       MAR_Load,
   output logic       PC_Load,
   output logic       PC_Inc,
   output logic       A_Load,
   output logic       B_Load,
   output logic [2:0] ALU_Sel,
   output logic       CCR_Load,
   output logic [1:0] Bus1_Sel,
   output logic [1:0] Bus2_Sel,
   output logic       write,
   output logic       halted
);

   state_t     state_q, state_d;
   logic       br_taken;
   logic       use_b;
   logic       ir_load_c, mar_load_c, pc_load_c, pc_inc_c;
   logic       a_load_c, b_load_c, ccr_load_c, write_c;
   logic [2:0] alu_sel_c;
   logic [1:0] bus1_sel_c, bus2_sel_c;

   branch_eval u_branch_eval (
      .IR         (IR),
      .CCR_Result (CCR_Result),
      .taken      (br_taken)
   );

   assign use_b = uses_reg_b(IR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= FETCH_0;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      ir_load_c  = 1'b0;
      mar_load_c = 1'b0;
      pc_load_c  = 1'b0;
      pc_inc_c   = 1'b0;
      a_load_c   = 1'b0;
      b_load_c   = 1'b0;
      ccr_load_c = 1'b0;
      write_c    = 1'b0;
      alu_sel_c  = ALU_ADD;
      bus1_sel_c = BUS1_PC;
      bus2_sel_c = BUS2_ALU;

      case (state_q)
         FETCH_0, LDI_4, LDD_4, ST_4, BRT_4: begin
            bus1_sel_c = BUS1_PC;
            bus2_sel_c = BUS2_BUS1;
            mar_load_c = 1'b1;
            case (state_q)
               FETCH_0: state_d = FETCH_1;
               LDI_4:   state_d = LDI_5;
               LDD_4:   state_d = LDD_5;
               ST_4:    state_d = ST_5;
               default: state_d = BRT_5;
            endcase
         end
         FETCH_1: begin
            pc_inc_c = 1'b1;
            state_d  = FETCH_2;
         end
         FETCH_2: begin
            bus2_sel_c = BUS2_MEM;
            ir_load_c  = 1'b1;
            state_d    = DECODE_3;
         end
         DECODE_3: begin
            case (IR)
               OP_LDA_IMM, OP_LDB_IMM: state_d = LDI_4;
               OP_LDA_DIR, OP_LDB_DIR: state_d = LDD_4;
               OP_STA_DIR, OP_STB_DIR: state_d = ST_4;
               OP_ADD_AB, OP_SUB_AB, OP_AND_AB, OP_OR_AB,
               OP_INCA, OP_INCB, OP_DECA, OP_DECB: state_d = ALU_4;
               OP_BRA, OP_BMI, OP_BEQ, OP_BNE, OP_BVS, OP_BCS:
                  state_d = br_taken ? BRT_4 : BRN_4;
`ifdef CU_ILLEGAL_TRAP_EN
               default: state_d = HALT;
`else
               default: state_d = FETCH_0;
`endif
            endcase
         end
         LDI_5: begin
            pc_inc_c = 1'b1;
            state_d  = LDI_6;
         end
         LDD_5: begin
            pc_inc_c = 1'b1;
            state_d  = LDD_6;
         end
         ST_5: begin
            pc_inc_c = 1'b1;
            state_d  = ST_6;
         end
         LDI_6, LDD_8: begin
            bus2_sel_c = BUS2_MEM;
            a_load_c   = ~use_b;
            b_load_c   = use_b;
            state_d    = FETCH_0;
         end
         // Operand byte is the target address; re-point MAR at it.
         LDD_6, ST_6: begin
            bus2_sel_c = BUS2_MEM;
            mar_load_c = 1'b1;
            state_d    = (state_q == LDD_6) ? LDD_7 : ST_7;
         end
         LDD_7: state_d = LDD_8;
         ST_7: begin
            bus1_sel_c = use_b ? BUS1_B : BUS1_A;
            write_c    = 1'b1;
            state_d    = FETCH_0;
         end
         ALU_4: begin
            bus1_sel_c = use_b ? BUS1_B : BUS1_A;
            bus2_sel_c = BUS2_ALU;
            alu_sel_c  = alu_code(IR);
            a_load_c   = ~use_b;
            b_load_c   = use_b;
            ccr_load_c = 1'b1;
            state_d    = FETCH_0;
         end
         BRT_5: state_d = BRT_6;
         BRT_6: begin
            bus2_sel_c = BUS2_MEM;
            pc_load_c  = 1'b1;
            state_d    = FETCH_0;
         end
         BRN_4: begin
            pc_inc_c = 1'b1;
            state_d  = FETCH_0;
         end
`ifdef CU_ILLEGAL_TRAP_EN
         HALT: state_d = HALT;
`endif
         default: state_d = FETCH_0;
      endcase
   end

   // Reset gates every output: state already sits at FETCH_0 during reset,
   // whose strobes must not reach the data path until release.
   assign IR_Load  = reset & ir_load_c;
   assign MAR_Load = reset & mar_load_c;
   assign PC_Load  = reset & pc_load_c;
   assign PC_Inc   = reset & pc_inc_c;
   assign A_Load   = reset & a_load_c;
   assign B_Load   = reset & b_load_c;
   assign CCR_Load = reset & ccr_load_c;
   assign write    = reset & write_c;
   assign ALU_Sel  = reset ? alu_sel_c  : 3'b000;
   assign Bus1_Sel = reset ? bus1_sel_c : 2'b00;
   assign Bus2_Sel = reset ? bus2_sel_c : 2'b00;

`ifdef CU_ILLEGAL_TRAP_EN
   assign halted = reset & (state_q == HALT);
`else
   assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed bench for control_unit with a small behavioural
// data path and memory around it. Strobe words are packed as
// {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, ALU_Sel[2:0],
//  CCR_Load, Bus1_Sel[1:0], Bus2_Sel[1:0], write, halted}.
module tb_control_unit;

   logic       clk;
   logic       rst_n;
   logic [7:0] ir_r;
   logic [3:0] ccr_in;
   logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, wr, halted;
   logic [2:0] ALU_Sel;
   logic [1:0] Bus1_Sel, Bus2_Sel;

   logic [7:0] pc, mar, a_r, b_r;
   logic [3:0] ccr_r;
   logic [7:0] mem [256];
   logic [7:0] bus1, bus2;
   logic [8:0] alu_t;
   logic       alu_v;
   logic [3:0] alu_flags;
   logic       prog_we;
   logic [7:0] prog_addr, prog_data;
   logic       ccr_force_en;
   logic [3:0] ccr_force;
   logic [15:0] strobes;

   int checks;
   int failures;

   control_unit dut (
      .clk        (clk),
      .reset      (rst_n),
      .IR         (ir_r),
      .CCR_Result (ccr_in),
      .IR_Load    (IR_Load),
      .MAR_Load   (MAR_Load),
      .PC_Load    (PC_Load),
      .PC_Inc     (PC_Inc),
      .A_Load     (A_Load),
      .B_Load     (B_Load),
      .ALU_Sel    (ALU_Sel),
      .CCR_Load   (CCR_Load),
      .Bus1_Sel   (Bus1_Sel),
      .Bus2_Sel   (Bus2_Sel),
      .write      (wr),
      .halted     (halted)
   );

   assign strobes = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, ALU_Sel,
                     CCR_Load, Bus1_Sel, Bus2_Sel, wr, halted};
   assign ccr_in  = ccr_force_en ? ccr_force : ccr_r;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      case (Bus1_Sel)
         2'b01:   bus1 = a_r;
         2'b10:   bus1 = b_r;
         default: bus1 = pc;
      endcase
      alu_v = 1'b0;
      case (ALU_Sel)
         3'b000: begin
            alu_t = {1'b0, bus1} + {1'b0, b_r};
            alu_v = (bus1[7] == b_r[7]) && (alu_t[7] != bus1[7]);
         end
         3'b001: begin
            alu_t = {1'b0, bus1} - {1'b0, b_r};
            alu_v = (bus1[7] != b_r[7]) && (alu_t[7] != bus1[7]);
         end
         3'b010: alu_t = {1'b0, bus1 & b_r};
         3'b011: alu_t = {1'b0, bus1 | b_r};
         3'b100: begin
            alu_t = {1'b0, bus1} + 9'd1;
            alu_v = (bus1 == 8'h7F);
         end
         3'b101: begin
            alu_t = {1'b0, bus1} - 9'd1;
            alu_v = (bus1 == 8'h80);
         end
         default: alu_t = 9'd0;
      endcase
      alu_flags = {alu_t[7], (alu_t[7:0] == 8'h00), alu_v, alu_t[8]};
      case (Bus2_Sel)
         2'b00:   bus2 = alu_t[7:0];
         2'b01:   bus2 = bus1;
         2'b10:   bus2 = mem[mar];
         default: bus2 = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc   <= 8'h00;
         mar  <= 8'h00;
         ir_r <= 8'h00;
      end else begin
         if (PC_Load)      pc <= bus2;
         else if (PC_Inc)  pc <= pc + 8'd1;
         if (MAR_Load)     mar  <= bus2;
         if (IR_Load)      ir_r <= bus2;
      end
   end

   always_ff @(posedge clk) begin
      if (A_Load)   a_r   <= bus2;
      if (B_Load)   b_r   <= bus2;
      if (CCR_Load) ccr_r <= alu_flags;
   end

   always_ff @(posedge clk) begin
      if (prog_we)  mem[prog_addr] <= prog_data;
      else if (wr)  mem[mar] <= bus1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic prog_byte(input logic [7:0] addr, input logic [7:0] data);
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = addr;
      prog_data = data;
      @(negedge clk);
      prog_we   = 1'b0;
   endtask

   task automatic prog_clear();
      rst_n = 1'b0;
      for (int i = 0; i < 256; i++) prog_byte(i[7:0], 8'h00);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      checks++;
      if (strobes !== 16'h0000) begin
         failures++;
         $display("FAIL reset_outputs: got %h expected %h", strobes, 16'h0000);
      end
   endtask

   task automatic test_lda_imm();
      logic [15:0] exp [7];
      exp = '{16'h4004, 16'h1000, 16'h8008, 16'h0000, 16'h4004, 16'h1000, 16'h0808};
      prog_clear();
      prog_byte(8'h00, 8'h86);
      prog_byte(8'h01, 8'hAA);
      release_reset();
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (strobes !== exp[i]) begin
            failures++;
            $display("FAIL lda_imm_cyc%0d: got %h expected %h", i + 1, strobes, exp[i]);
         end
         step();
      end
      checks++;
      if (strobes !== 16'h4004 || pc !== 8'h02) begin
         failures++;
         $display("FAIL lda_imm_next_fetch: got strobes %h pc %h expected 4004 pc 02", strobes, pc);
      end
      checks++;
      if (a_r !== 8'hAA) begin
         failures++;
         $display("FAIL lda_imm_a: got %h expected aa", a_r);
      end
   endtask

   task automatic test_ldb_dir();
      logic [15:0] exp [9];
      exp = '{16'h4004, 16'h1000, 16'h8008, 16'h0000, 16'h4004, 16'h1000,
              16'h4008, 16'h0000, 16'h0408};
      prog_clear();
      prog_byte(8'h00, 8'h89);
      prog_byte(8'h01, 8'h20);
      prog_byte(8'h20, 8'h77);
      release_reset();
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (strobes !== exp[i]) begin
            failures++;
            $display("FAIL ldb_dir_cyc%0d: got %h expected %h", i + 1, strobes, exp[i]);
         end
         step();
      end
      checks++;
      if (strobes !== 16'h4004 || pc !== 8'h02 || b_r !== 8'h77) begin
         failures++;
         $display("FAIL ldb_dir_result: got strobes %h pc %h b %h expected 4004 02 77", strobes, pc, b_r);
      end
   endtask

   task automatic test_store();
      logic [15:0] exp [8];
      int wr_cycles;
      exp = '{16'h4004, 16'h1000, 16'h8008, 16'h0000, 16'h4004, 16'h1000,
              16'h4008, 16'h0012};
      wr_cycles = 0;
      prog_clear();
      prog_byte(8'h00, 8'h86);
      prog_byte(8'h01, 8'h5C);
      prog_byte(8'h02, 8'h96);
      prog_byte(8'h03, 8'hE0);
      release_reset();
      repeat (7) step();
      for (int i = 0; i < 8; i++) begin
         if (wr) wr_cycles++;
         checks++;
         if (strobes !== exp[i]) begin
            failures++;
            $display("FAIL sta_cyc%0d: got %h expected %h", i + 1, strobes, exp[i]);
         end
         if (i == 7) begin
            checks++;
            if (mar !== 8'hE0) begin
               failures++;
               $display("FAIL sta_mar: got %h expected e0", mar);
            end
         end
         step();
      end
      if (wr) wr_cycles++;
      checks++;
      if (wr_cycles != 1) begin
         failures++;
         $display("FAIL sta_write_cycles: got %0d expected 1", wr_cycles);
      end
      checks++;
      if (strobes !== 16'h4004 || pc !== 8'h04 || mem[8'hE0] !== 8'h5C) begin
         failures++;
         $display("FAIL sta_result: got strobes %h pc %h mem %h expected 4004 04 5c",
                  strobes, pc, mem[8'hE0]);
      end
   endtask

   task automatic test_alu_add();
      logic [15:0] exp [5];
      exp = '{16'h4004, 16'h1000, 16'h8008, 16'h0000, 16'h0850};
      prog_clear();
      prog_byte(8'h00, 8'h86);
      prog_byte(8'h01, 8'h7F);
      prog_byte(8'h02, 8'h88);
      prog_byte(8'h03, 8'h01);
      prog_byte(8'h04, 8'h42);
      release_reset();
      repeat (14) step();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (strobes !== exp[i]) begin
            failures++;
            $display("FAIL add_cyc%0d: got %h expected %h", i + 1, strobes, exp[i]);
         end
         step();
      end
      checks++;
      if (strobes !== 16'h4004 || pc !== 8'h05 || a_r !== 8'h80 || ccr_r !== 4'b1010) begin
         failures++;
         $display("FAIL add_result: got strobes %h pc %h a %h ccr %b expected 4004 05 80 1010",
                  strobes, pc, a_r, ccr_r);
      end
   endtask

   task automatic test_alu_codes();
      logic [7:0]  ops [8];
      logic [15:0] words [8];
      ops   = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49};
      words = '{16'h0850, 16'h08D0, 16'h0950, 16'h09D0, 16'h0A50, 16'h0660, 16'h0AD0, 16'h06E0};
      for (int k = 0; k < 8; k++) begin
         prog_clear();
         prog_byte(8'h00, ops[k]);
         release_reset();
         repeat (4) step();
         checks++;
         if (strobes !== words[k]) begin
            failures++;
            $display("FAIL alu_op_%h: got %h expected %h", ops[k], strobes, words[k]);
         end
         step();
         checks++;
         if (strobes !== 16'h4004 || pc !== 8'h01) begin
            failures++;
            $display("FAIL alu_op_%h_next: got strobes %h pc %h expected 4004 01", ops[k], strobes, pc);
         end
      end
   endtask

   task automatic test_branches();
      logic [7:0] ops [10];
      logic [3:0] flags [10];
      logic       tk [10];
      ops   = '{8'h23, 8'h23, 8'h20, 8'h21, 8'h21, 8'h24, 8'h24, 8'h25, 8'h27, 8'h27};
      flags = '{4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0100, 4'b0000,
                4'b0010, 4'b0000, 4'b0001};
      tk    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      ccr_force_en = 1'b1;
      for (int k = 0; k < 10; k++) begin
         ccr_force = flags[k];
         prog_clear();
         prog_byte(8'h00, ops[k]);
         prog_byte(8'h01, 8'h40);
         release_reset();
         repeat (4) step();
         if (tk[k]) begin
            checks++;
            if (strobes !== 16'h4004) begin
               failures++;
               $display("FAIL br%0d_taken_s4: got %h expected 4004", k, strobes);
            end
            step();
            checks++;
            if (strobes !== 16'h0000) begin
               failures++;
               $display("FAIL br%0d_taken_s5: got %h expected 0000", k, strobes);
            end
            step();
            checks++;
            if (strobes !== 16'h2008) begin
               failures++;
               $display("FAIL br%0d_taken_s6: got %h expected 2008", k, strobes);
            end
            step();
            checks++;
            if (strobes !== 16'h4004 || pc !== 8'h40) begin
               failures++;
               $display("FAIL br%0d_taken_next: got strobes %h pc %h expected 4004 40", k, strobes, pc);
            end
         end else begin
            checks++;
            if (strobes !== 16'h1000) begin
               failures++;
               $display("FAIL br%0d_skip_s4: got %h expected 1000", k, strobes);
            end
            step();
            checks++;
            if (strobes !== 16'h4004 || pc !== 8'h02) begin
               failures++;
               $display("FAIL br%0d_skip_next: got strobes %h pc %h expected 4004 02", k, strobes, pc);
            end
         end
      end
      ccr_force_en = 1'b0;
   endtask

   task automatic test_reset_abort();
      prog_clear();
      prog_byte(8'h00, 8'h86);
      prog_byte(8'h01, 8'h33);
      prog_byte(8'h02, 8'h87);
      prog_byte(8'h03, 8'h10);
      prog_byte(8'h10, 8'h99);
      release_reset();
      repeat (14) step();
      checks++;
      if (strobes !== 16'h0000 || mar !== 8'h10) begin
         failures++;
         $display("FAIL abort_in_s7: got strobes %h mar %h expected 0000 10", strobes, mar);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (strobes !== 16'h0000) begin
         failures++;
         $display("FAIL abort_outputs_now: got %h expected 0000", strobes);
      end
      repeat (3) step();
      checks++;
      if (strobes !== 16'h0000 || a_r !== 8'h33) begin
         failures++;
         $display("FAIL abort_held: got strobes %h a %h expected 0000 33", strobes, a_r);
      end
      release_reset();
      checks++;
      if (strobes !== 16'h4004 || pc !== 8'h00) begin
         failures++;
         $display("FAIL abort_restart: got strobes %h pc %h expected 4004 00", strobes, pc);
      end
      repeat (2) step();
      checks++;
      if (a_r !== 8'h33) begin
         failures++;
         $display("FAIL abort_a_kept: got %h expected 33", a_r);
      end
   endtask

   task automatic test_unknown_opcode();
      prog_clear();
      prog_byte(8'h00, 8'hFF);
      release_reset();
      repeat (4) step();
`ifdef CU_ILLEGAL_TRAP_EN
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (strobes !== 16'h0001) begin
            failures++;
            $display("FAIL halt_cyc%0d: got %h expected 0001", i, strobes);
         end
         step();
      end
`else
      checks++;
      if (strobes !== 16'h4004 || pc !== 8'h01) begin
         failures++;
         $display("FAIL unknown_nop: got strobes %h pc %h expected 4004 01", strobes, pc);
      end
`endif
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rst_n        = 1'b0;
      prog_we      = 1'b0;
      prog_addr    = 8'h00;
      prog_data    = 8'h00;
      ccr_force_en = 1'b0;
      ccr_force    = 4'b0000;
      test_reset();
      test_lda_imm();
      test_ldb_dir();
      test_store();
      test_alu_add();
      test_alu_codes();
      test_branches();
      test_reset_abort();
      test_unknown_opcode();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
